// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
package mips_pkg;

    localparam int unsigned MipsWidth = 32;

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101,
        OpNop0  = 3'b110,
        OpNop1  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } muldiv_state_t;

endpackage

// File: rtl/mips_div_step.sv
// One radix-2 restoring divide iteration on unsigned magnitudes.
module mips_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, dividend_bit};
    assign quo_bit = (shifted >= {1'b0, divisor});
    // The difference always fits in WIDTH bits when the subtract is taken.
    assign rem_out = quo_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/mips_muldiv.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the Execute stage.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH      = MipsWidth,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [2:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             AbortE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] HiE,
    output logic [WIDTH-1:0] LoE
);

    localparam int unsigned CntMax = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    muldiv_state_t state_q, state_d;
    muldiv_op_t    op;

    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_raw_q, a_raw_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               done_q, done_d, sgn_q, sgn_d, qneg_q, qneg_d;
    logic               rneg_q, rneg_d, dbz_q, dbz_d;

    logic               accept, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b, step_rem, step_quo;
    logic               step_bit;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod_full;

    assign op        = muldiv_op_t'(OpE);
    assign accept    = (state_q == StIdle) && StartE && !AbortE;
    assign signed_op = !OpE[0];
    assign a_neg     = signed_op && SrcAE[WIDTH-1];
    assign b_neg     = signed_op && SrcBE[WIDTH-1];
    assign abs_a     = a_neg ? -SrcAE : SrcAE;
    assign abs_b     = b_neg ? -SrcBE : SrcBE;
    assign ext_a     = {{WIDTH{a_neg}}, SrcAE};
    assign ext_b     = {{WIDTH{b_neg}}, SrcBE};
    assign prod_full = ext_a * ext_b;
    assign step_quo  = {quo_q[WIDTH-2:0], step_bit};

    mips_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (rem_q),
        .dividend_bit (quo_q[WIDTH-1]),
        .divisor      (dvs_q),
        .rem_out      (step_rem),
        .quo_bit      (step_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpMult || op == OpMultu)    state_d = StMul;
                    else if (op == OpDiv || op == OpDivu) state_d = StDiv;
                end
            end
            StMul: if (AbortE || cnt_q == '0) state_d = StIdle;
            StDiv: begin
                if (AbortE)              state_d = StIdle;
                else if (cnt_q == '0)    state_d = sgn_q ? StFix : StIdle;
            end
            StFix: state_d = StIdle;
        endcase
    end

    always_comb begin
        BusyE = (state_q != StIdle);
        DoneE = done_q;
        HiE   = hi_q;
        LoE   = lo_q;
    end

    always_comb begin
        hi_d = hi_q;  lo_d = lo_q;  rem_d = rem_q;  quo_d = quo_q;  dvs_d = dvs_q;
        a_raw_d = a_raw_q;  prod_d = prod_q;  cnt_d = cnt_q;  sgn_d = sgn_q;
        qneg_d = qneg_q;  rneg_d = rneg_q;  dbz_d = dbz_q;  done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op)
                        OpMult, OpMultu: begin
                            prod_d = prod_full;
                            cnt_d  = CntW'(MUL_CYCLES - 1);
                        end
                        OpDiv, OpDivu: begin
                            quo_d   = abs_a;
                            rem_d   = '0;
                            dvs_d   = abs_b;
                            a_raw_d = SrcAE;
                            sgn_d   = signed_op;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            dbz_d   = (SrcBE == '0);
                            cnt_d   = CntW'(WIDTH - 1);
                        end
                        OpMthi:  hi_d = SrcAE;
                        OpMtlo:  lo_d = SrcAE;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (!AbortE) begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = prod_q;
                        done_d       = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StDiv: begin
                if (!AbortE) begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!sgn_q) begin
                        lo_d   = dbz_q ? '1 : step_quo;
                        hi_d   = dbz_q ? a_raw_q : step_rem;
                        done_d = 1'b1;
                    end
                end
            end
            StFix: begin
                // Divide-by-zero bypasses sign fixing so LO stays all ones.
                if (!AbortE) begin
                    lo_d   = dbz_q ? '1 : (qneg_q ? -quo_q : quo_q);
                    hi_d   = dbz_q ? a_raw_q : (rneg_q ? -rem_q : rem_q);
                    done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;  lo_q <= '0;  rem_q <= '0;  quo_q <= '0;  dvs_q <= '0;
            a_raw_q <= '0;  prod_q <= '0;  cnt_q <= '0;  done_q <= 1'b0;
            sgn_q <= 1'b0;  qneg_q <= 1'b0;  rneg_q <= 1'b0;  dbz_q <= 1'b0;
        end else begin
            hi_q <= hi_d;  lo_q <= lo_d;  rem_q <= rem_d;  quo_q <= quo_d;  dvs_q <= dvs_d;
            a_raw_q <= a_raw_d;  prod_q <= prod_d;  cnt_q <= cnt_d;  done_q <= done_d;
            sgn_q <= sgn_d;  qneg_q <= qneg_d;  rneg_q <= rneg_d;  dbz_q <= dbz_d;
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed-vector bench for mips_muldiv at WIDTH=32, MUL_CYCLES=4.
module tb_mips_muldiv;

    logic        clk = 1'b0;
    logic        reset, StartE, AbortE;
    logic [2:0]  OpE;
    logic [31:0] SrcAE, SrcBE;
    logic        BusyE, DoneE;
    logic [31:0] HiE, LoE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(32), .MUL_CYCLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .StartE (StartE),
        .OpE    (OpE),
        .SrcAE  (SrcAE),
        .SrcBE  (SrcBE),
        .AbortE (AbortE),
        .BusyE  (BusyE),
        .DoneE  (DoneE),
        .HiE    (HiE),
        .LoE    (LoE)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one op, then counts Busy cycles; returns in the first non-busy cycle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy);
        StartE = 1'b1;  OpE = op;  SrcAE = a;  SrcBE = b;
        tick();
        StartE = 1'b0;  SrcAE = 32'hA5A5_5A5A;  SrcBE = 32'h5A5A_A5A5;
        busy = 0;
        while (BusyE && busy < 100) begin
            busy++;
            tick();
        end
    endtask

    initial begin
        int busy;
        logic seen_done;

        vecs[0] = '{"mult_neg1x2",   3'b000, 32'hFFFF_FFFF, 32'h2, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{"multu_maxx2",   3'b001, 32'hFFFF_FFFF, 32'h2, 4, 32'h1, 32'hFFFF_FFFE};
        vecs[2] = '{"mult_minxmin",  3'b000, 32'h8000_0000, 32'h8000_0000, 4, 32'h4000_0000, 32'h0};
        vecs[3] = '{"div_m7_2",      3'b010, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{"div_7_m2",      3'b010, 32'h7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD};
        vecs[5] = '{"divu_100_7",    3'b011, 32'd100, 32'd7, 32, 32'd2, 32'd14};
        vecs[6] = '{"divu_by0",      3'b011, 32'h64, 32'h0, 32, 32'h64, 32'hFFFF_FFFF};
        vecs[7] = '{"div_overflow",  3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000};
        vecs[8] = '{"div_m5_by0",    3'b010, 32'hFFFF_FFFB, 32'h0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

        reset = 1'b1;  StartE = 1'b0;  AbortE = 1'b0;  OpE = 3'b111;  SrcAE = '0;  SrcBE = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", 32'(BusyE), 32'd0);
        check("reset_done", 32'(DoneE), 32'd0);
        check("reset_hi", HiE, 32'h0);
        check("reset_lo", LoE, 32'h0);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, busy);
            check({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].busy));
            check({vecs[i].name, "_done"}, 32'(DoneE), 32'd1);
            check({vecs[i].name, "_hi"}, HiE, vecs[i].hi);
            check({vecs[i].name, "_lo"}, LoE, vecs[i].lo);
            tick();
            check({vecs[i].name, "_done_clr"}, 32'(DoneE), 32'd0);
        end

        // MTHI then MTLO on consecutive cycles.
        StartE = 1'b1;  OpE = 3'b100;  SrcAE = 32'h1234;
        tick();
        check("mthi_hi", HiE, 32'h1234);
        check("mthi_busy", 32'(BusyE), 32'd0);
        OpE = 3'b101;  SrcAE = 32'h5678;
        tick();
        StartE = 1'b0;
        check("mtlo_lo", LoE, 32'h5678);
        check("mtlo_hi", HiE, 32'h1234);
        check("mtlo_busy", 32'(BusyE), 32'd0);
        check("mtlo_done", 32'(DoneE), 32'd0);

        // No-op opcode must leave everything alone.
        StartE = 1'b1;  OpE = 3'b110;  SrcAE = 32'hDEAD_BEEF;
        tick();
        StartE = 1'b0;
        check("nop_busy", 32'(BusyE), 32'd0);
        check("nop_hi", HiE, 32'h1234);

        // Abort a DIV in its 10th busy cycle, with a stray MTHI start mid-busy.
        StartE = 1'b1;  OpE = 3'b010;  SrcAE = 32'd100;  SrcBE = 32'd7;
        tick();
        for (int i = 1; i <= 10; i++) begin
            StartE = (i == 5);
            OpE    = (i == 5) ? 3'b100 : 3'b010;
            SrcAE  = 32'hDEAD_0000;
            AbortE = (i == 10);
            if (i == 10) check("abort_busy_before", 32'(BusyE), 32'd1);
            tick();
        end
        StartE = 1'b0;  AbortE = 1'b0;
        check("abort_busy_after", 32'(BusyE), 32'd0);
        check("abort_done", 32'(DoneE), 32'd0);
        check("abort_hi", HiE, 32'h1234);
        check("abort_lo", LoE, 32'h5678);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen_done |= DoneE | BusyE;
            tick();
        end
        check("abort_quiet", 32'(seen_done), 32'd0);

        // Reset in the 2nd MUL cycle.
        StartE = 1'b1;  OpE = 3'b000;  SrcAE = 32'd3;  SrcBE = 32'd5;
        tick();
        StartE = 1'b0;
        tick();
        check("rst_mid_busy_before", 32'(BusyE), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", 32'(BusyE), 32'd0);
        check("rst_mid_hi", HiE, 32'h0);
        check("rst_mid_lo", LoE, 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen_done |= DoneE | BusyE;
            tick();
        end
        check("rst_mid_quiet", 32'(seen_done), 32'd0);

        // Back-to-back MULT accepted in the DoneE cycle.
        do_op(3'b001, 32'd3, 32'd5, busy);
        check("b2b_first_done", 32'(DoneE), 32'd1);
        check("b2b_first_lo", LoE, 32'd15);
        do_op(3'b000, 32'd6, 32'hFFFF_FFF9, busy);
        check("b2b_second_busy", 32'(busy), 32'd4);
        check("b2b_second_done", 32'(DoneE), 32'd1);
        check("b2b_second_hi", HiE, 32'hFFFF_FFFF);
        check("b2b_second_lo", LoE, 32'hFFFF_FFD6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
